i2c_slave_regfile: RTL

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

---
 rtl/i2c_slave_regfile.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C responder with 32x8 register file; define I2C_SLAVE_AUTOINC_EN for pointer auto-increment
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic       loc_w,
    input  logic [4:0] loc_wadd,
    input  logic [7:0] loc_din,
    input  logic [4:0] loc_radd,
    output logic [7:0] loc_rdout,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] tx_q, tx_d;
    logic       sda_oe_q, sda_oe_d;
    logic       ack_half_q, ack_half_d;
    logic       rw_q, rw_d;
    logic [4:0] ptr_q, ptr_d, ptr_next;
    logic       busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [4:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] loc_rdout_q, loc_rdout_d;
    logic [7:0] rf_q [32];
    logic [7:0] rf_d [32];
    logic [7:0] rx_byte;
    logic       bus_we, load_tx;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q, sda_s};

`ifdef I2C_SLAVE_AUTOINC_EN
    assign ptr_next = ptr_q + 5'd1;
`else
    assign ptr_next = ptr_q;
`endif

    // Reset gates the driver directly so sda is released without waiting for a clock
    assign sda       = (sda_oe_q && reset) ? 1'b0 : 1'bz;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign loc_rdout = loc_rdout_q;

    // Shift raw bus lines through the synchronizer chain and keep last synchronized value
    always_comb begin
        scl_sync_d[0] = scl;
        sda_sync_d[0] = sda;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync_d[i] = scl_sync_q[i-1];
            sda_sync_d[i] = sda_sync_q[i-1];
        end
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Protocol FSM: ACK slots drive on the first scl fall and finish on the second
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        sda_oe_d    = sda_oe_q;
        ack_half_d  = ack_half_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        bus_we      = 1'b0;
        load_tx     = 1'b0;
        if (start_det) begin
            state_d    = ADDR;
            bit_cnt_d  = 3'd0;
            sda_oe_d   = 1'b0;
            ack_half_d = 1'b0;
            busy_d     = 1'b0;
        end else if (stop_det) begin
            state_d    = IDLE;
            sda_oe_d   = 1'b0;
            ack_half_d = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    state_d = ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte[4:0];
                                state_d = PTR_ACK;
                            end else begin
                                bus_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                                ptr_d       = ptr_next;
                                state_d     = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_rise) begin
                        ack_half_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_half_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_half_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                load_tx = 1'b1;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = (state_q == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RDATA_ACK;
                        end
                    end else if (scl_fall) begin
                        tx_d     = {tx_q[5:0], 1'b0};
                        sda_oe_d = ~tx_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = IGNORE;
                        end else begin
                            ack_half_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (!ack_half_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            ack_half_d = 1'b0;
                            load_tx    = 1'b1;
                        end
                    end
                end
                IDLE, IGNORE: begin
                    state_d = state_q;
                end
                default: state_d = IDLE;
            endcase
            if (load_tx) begin
                tx_d      = rf_q[ptr_q][6:0];
                sda_oe_d  = ~rf_q[ptr_q][7];
                ptr_d     = ptr_next;
                bit_cnt_d = 3'd0;
                state_d   = RDATA;
            end
        end
    end

    // Register file writes: bus write is applied last so it wins on an address clash
    always_comb begin
        rf_d = rf_q;
        if (loc_w) begin
            rf_d[loc_wadd] = loc_din;
        end
        if (bus_we) begin
            rf_d[ptr_q] = rx_byte;
        end
        loc_rdout_d = rf_q[loc_radd];
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            tx_q        <= 7'd0;
            sda_oe_q    <= 1'b0;
            ack_half_q  <= 1'b0;
            rw_q        <= 1'b0;
            ptr_q       <= 5'd0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 8'd0;
            loc_rdout_q <= 8'd0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            sda_oe_q    <= sda_oe_d;
            ack_half_q  <= ack_half_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            loc_rdout_q <= loc_rdout_d;
            rf_q        <= rf_d;
        end
    end

endmodule
